// File: rtl/id_exe_stage_pkg.sv
// Shared encodings and the ID/EXE bundle for the id_exe_stage slice.
// mem_reg values select the writeback source; only MEMREG_ALU is forwardable.
package id_exe_stage_pkg;

    localparam int ALU_OP_W = 4;
    localparam int MEM_REG_W = 3;

    localparam logic [MEM_REG_W-1:0] MEMREG_ALU = 3'b001;
    localparam logic [MEM_REG_W-1:0] MEMREG_LW  = 3'b010;
    localparam logic [MEM_REG_W-1:0] MEMREG_LH  = 3'b011;
    localparam logic [MEM_REG_W-1:0] MEMREG_LHU = 3'b100;
    localparam logic [MEM_REG_W-1:0] MEMREG_LB  = 3'b101;
    localparam logic [MEM_REG_W-1:0] MEMREG_LBU = 3'b110;

    typedef struct packed {
        logic                 valid;
        logic [31:0]          a;
        logic [31:0]          b;
        logic [31:0]          imm;
        logic [4:0]           dreg;
        logic                 we;
        logic [MEM_REG_W-1:0] mem_reg;
        logic [ALU_OP_W-1:0]  alu_op;
    } id_ex_t;

    localparam id_ex_t EXE_BUBBLE = '{
        valid:   1'b0,
        a:       32'd0,
        b:       32'd0,
        imm:     32'd0,
        dreg:    5'd0,
        we:      1'b0,
        mem_reg: MEMREG_ALU,
        alu_op:  '0
    };

endpackage

// File: rtl/id_exe_stage_hazard_detect.sv
// Load-use hazard detection between the ID instruction and the EXE producer.
// ALU results are forwarded, so only non-ALU writers to a live register stall.
module hazard_detect
    import id_exe_stage_pkg::*;
(
    input  logic                 id_valid,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_use_rs,
    input  logic                 id_use_rt,
    input  logic                 exe_valid,
    input  logic                 exe_we,
    input  logic [4:0]           exe_dreg,
    input  logic [MEM_REG_W-1:0] exe_mem_reg,
    output logic                 hazard
);

    logic producer_late;
    logic rs_hit;
    logic rt_hit;

    always_comb begin
        producer_late = exe_valid & exe_we
                      & (exe_dreg != 5'd0)
                      & (exe_mem_reg != MEMREG_ALU);
        rs_hit = id_use_rs & (id_rs == exe_dreg);
        rt_hit = id_use_rt & (id_rt == exe_dreg);
        hazard = id_valid & producer_late & (rs_hit | rt_hit);
    end

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with load-use bubble insertion and a
// saturating count of the bubbles it inserted.
module id_exe_stage
    import id_exe_stage_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic [31:0]            id_a,
    input  logic [31:0]            id_b,
    input  logic [31:0]            id_imm,
    input  logic [4:0]             id_dreg,
    input  logic                   id_we,
    input  logic [MEM_REG_W-1:0]   id_mem_reg,
    input  logic [ALU_OP_W-1:0]    id_alu_op,
    input  logic                   exe_flush,
    input  logic                   ext_stall,
    output logic                   exe_valid,
    output logic [31:0]            exe_a,
    output logic [31:0]            exe_b,
    output logic [31:0]            exe_imm,
    output logic [4:0]             exe_dreg,
    output logic                   exe_we,
    output logic [MEM_REG_W-1:0]   exe_mem_reg,
    output logic [ALU_OP_W-1:0]    exe_alu_op,
    output logic                   stall_if_id,
    output logic [STALL_CNT_W-1:0] lu_stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] CNT_ONE =
        {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    id_ex_t exe_q;
    id_ex_t id_pkt;
    logic   hazard;

    hazard_detect u_hazard (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .exe_valid   (exe_q.valid),
        .exe_we      (exe_q.we),
        .exe_dreg    (exe_q.dreg),
        .exe_mem_reg (exe_q.mem_reg),
        .hazard      (hazard)
    );

    // A non-instruction must never reach writeback with its write enable set.
    always_comb begin
        id_pkt.valid   = id_valid;
        id_pkt.a       = id_a;
        id_pkt.b       = id_b;
        id_pkt.imm     = id_imm;
        id_pkt.dreg    = id_dreg;
        id_pkt.we      = id_we & id_valid;
        id_pkt.mem_reg = id_mem_reg;
        id_pkt.alu_op  = id_alu_op;
    end

    always_comb begin
        stall_if_id = ext_stall | (hazard & ~exe_flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_q        <= EXE_BUBBLE;
            lu_stall_cnt <= '0;
        end else if (!ext_stall) begin
            if (exe_flush) begin
                exe_q <= EXE_BUBBLE;
            end else if (hazard) begin
                exe_q <= EXE_BUBBLE;
                if (lu_stall_cnt != '1) begin
                    lu_stall_cnt <= lu_stall_cnt + CNT_ONE;
                end
            end else begin
                exe_q <= id_pkt;
            end
        end
    end

    always_comb begin
        exe_valid   = exe_q.valid;
        exe_a       = exe_q.a;
        exe_b       = exe_q.b;
        exe_imm     = exe_q.imm;
        exe_dreg    = exe_q.dreg;
        exe_we      = exe_q.we;
        exe_mem_reg = exe_q.mem_reg;
        exe_alu_op  = exe_q.alu_op;
    end

endmodule
